// File: rtl/prefix_pkg.sv
// Shared x86 legacy-prefix definitions used by the prefix encoder and the prefix decoder.
// Holds prefix byte values, segment index encodings, the group 1 select and encoder FSM types.
package prefix_pkg;

    localparam logic [7:0] PREFIX_LOCK    = 8'hF0;
    localparam logic [7:0] PREFIX_REPNE   = 8'hF2;
    localparam logic [7:0] PREFIX_REP     = 8'hF3;
    localparam logic [7:0] PREFIX_OPSZ    = 8'h66;
    localparam logic [7:0] PREFIX_ADSZ    = 8'h67;
    localparam logic [7:0] PREFIX_SEG_ES  = 8'h26;
    localparam logic [7:0] PREFIX_SEG_CS  = 8'h2E;
    localparam logic [7:0] PREFIX_SEG_SS  = 8'h36;
    localparam logic [7:0] PREFIX_SEG_DS  = 8'h3E;
    localparam logic [7:0] PREFIX_SEG_FS  = 8'h64;
    localparam logic [7:0] PREFIX_SEG_GS  = 8'h65;

    // Segment register indices as encoded in ModRM/sreg fields; 6 and 7 are unused.
    localparam logic [2:0] index_reg_seg__es = 3'd0;
    localparam logic [2:0] index_reg_seg__cs = 3'd1;
    localparam logic [2:0] index_reg_seg__ss = 3'd2;
    localparam logic [2:0] index_reg_seg__ds = 3'd3;
    localparam logic [2:0] index_reg_seg__fs = 3'd4;
    localparam logic [2:0] index_reg_seg__gs = 3'd5;

    typedef enum logic [1:0] {
        G1_NONE  = 2'b00,
        G1_LOCK  = 2'b01,
        G1_REPNE = 2'b10,
        G1_REP   = 2'b11
    } group_1_t;

    // Declaration order is the emission order; next_present relies on it.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_G1,
        ST_SEG,
        ST_OPSZ,
        ST_ADSZ,
        ST_BODY
    } state_t;

    // present = {address_size, operand_size, segment, group_1}
    function automatic state_t next_present(input state_t cur, input logic [3:0] present);
        state_t n;
        n = ST_BODY;
        if (cur < ST_G1 && present[0])
            n = ST_G1;
        else if (cur < ST_SEG && present[1])
            n = ST_SEG;
        else if (cur < ST_OPSZ && present[2])
            n = ST_OPSZ;
        else if (cur < ST_ADSZ && present[3])
            n = ST_ADSZ;
        return n;
    endfunction

endpackage

// File: rtl/encode_prefix_if.sv
// Request and byte-stream bundle of the prefix encoder; slave is the encoder, master the requester/consumer.
interface encode_prefix_if #(parameter int MAX_BODY_BYTES = 15);
    import prefix_pkg::*;

    logic           i_valid;
    logic           o_ready;
    group_1_t       i_group_1_select;
    logic           i_segment_override_en;
    logic [2:0]     i_segment_override_index;
    logic           i_operand_size;
    logic           i_address_size;
    logic [3:0]     i_body_length;
    logic [7:0]     i_body [MAX_BODY_BYTES];
    logic           o_byte_valid;
    logic [7:0]     o_byte;
    logic           o_byte_last;
    logic           i_byte_ready;
    logic           o_length_error;
    logic           o_busy;

    modport slave (
        input  i_valid, i_group_1_select, i_segment_override_en, i_segment_override_index,
               i_operand_size, i_address_size, i_body_length, i_body, i_byte_ready,
        output o_ready, o_byte_valid, o_byte, o_byte_last, o_length_error, o_busy
    );

    modport master (
        output i_valid, i_group_1_select, i_segment_override_en, i_segment_override_index,
               i_operand_size, i_address_size, i_body_length, i_body, i_byte_ready,
        input  o_ready, o_byte_valid, o_byte, o_byte_last, o_length_error, o_busy
    );

endinterface

// File: rtl/encode_prefix_segment_byte.sv
// Maps a segment register index to its override prefix byte; indices 6/7 have no prefix.
module encode_prefix_segment_byte
    import prefix_pkg::*;
(
    input  logic [2:0] index,
    output logic       seg_valid,
    output logic [7:0] seg_byte
);

    always_comb begin
        seg_valid = 1'b1;
        seg_byte  = 8'h00;
        case (index)
            index_reg_seg__es: seg_byte = PREFIX_SEG_ES;
            index_reg_seg__cs: seg_byte = PREFIX_SEG_CS;
            index_reg_seg__ss: seg_byte = PREFIX_SEG_SS;
            index_reg_seg__ds: seg_byte = PREFIX_SEG_DS;
            index_reg_seg__fs: seg_byte = PREFIX_SEG_FS;
            index_reg_seg__gs: seg_byte = PREFIX_SEG_GS;
            default:           seg_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/encode_prefix.sv
// Serializes one instruction request into group 1..4 legacy prefixes followed by body bytes,
// rejecting requests that would exceed the architectural instruction length.
module encode_prefix
    import prefix_pkg::*;
#(
    parameter int MAX_BODY_BYTES = 15,
    parameter int MAX_INSN_LEN   = 15
) (
    input  logic           i_clock,
    input  logic           i_reset_n,
    encode_prefix_if.slave bus
);

    localparam logic [4:0] BODY_LIMIT = 5'(MAX_BODY_BYTES);
    localparam logic [4:0] INSN_LIMIT = 5'(MAX_INSN_LEN);

    state_t     state_reg, state_next;
    logic [3:0] index_reg, index_next;
    group_1_t   g1_reg;
    logic       seg_present_reg;
    logic [7:0] seg_byte_reg;
    logic       opsz_reg, adsz_reg;
    logic [3:0] body_len_reg;
    logic       length_error_reg;
    logic [MAX_BODY_BYTES*8-1:0] body_flat;

    logic       in_seg_valid;
    logic [7:0] in_seg_byte;
    logic       seg_present_in;
    logic [2:0] prefix_count;
    logic [4:0] total_len;
    logic       accept, reject, body_last;
    logic [7:0] g1_byte;

    encode_prefix_segment_byte u_segment_byte (
        .index     (bus.i_segment_override_index),
        .seg_valid (in_seg_valid),
        .seg_byte  (in_seg_byte)
    );

    assign accept         = bus.i_valid && (state_reg == ST_IDLE);
    assign seg_present_in = bus.i_segment_override_en && in_seg_valid;
    assign prefix_count   = 3'(bus.i_group_1_select != G1_NONE) + 3'(seg_present_in)
                          + 3'(bus.i_operand_size) + 3'(bus.i_address_size);
    assign total_len      = {2'b00, prefix_count} + {1'b0, bus.i_body_length};
    assign reject         = (bus.i_body_length == 4'd0) || ({1'b0, bus.i_body_length} > BODY_LIMIT)
                          || (total_len > INSN_LIMIT);
    assign body_last      = (index_reg == body_len_reg - 4'd1);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg        <= ST_IDLE;
            index_reg        <= 4'd0;
            length_error_reg <= 1'b0;
            g1_reg           <= G1_NONE;
            seg_present_reg  <= 1'b0;
            seg_byte_reg     <= 8'h00;
            opsz_reg         <= 1'b0;
            adsz_reg         <= 1'b0;
            body_len_reg     <= 4'd0;
        end else begin
            state_reg        <= state_next;
            index_reg        <= index_next;
            length_error_reg <= accept && reject;
            if (accept) begin
                g1_reg          <= bus.i_group_1_select;
                seg_present_reg <= seg_present_in;
                seg_byte_reg    <= in_seg_byte;
                opsz_reg        <= bus.i_operand_size;
                adsz_reg        <= bus.i_address_size;
                body_len_reg    <= bus.i_body_length;
            end
        end
    end

    for (genvar gi = 0; gi < MAX_BODY_BYTES; gi++) begin : g_body
        logic [7:0] byte_reg;
        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n)
                byte_reg <= 8'h00;
            else if (accept)
                byte_reg <= bus.i_body[gi];
        end
        assign body_flat[gi*8 +: 8] = byte_reg;
    end

    always_comb begin
        g1_byte = 8'h00;
        case (g1_reg)
            G1_LOCK:  g1_byte = PREFIX_LOCK;
            G1_REPNE: g1_byte = PREFIX_REPNE;
            G1_REP:   g1_byte = PREFIX_REP;
            default:  g1_byte = 8'h00;
        endcase
    end

    // Byte outputs depend only on registered state, so they hold while the consumer stalls.
    always_comb begin
        state_next       = state_reg;
        index_next       = index_reg;
        bus.o_byte_valid = 1'b1;
        bus.o_byte       = 8'h00;
        bus.o_byte_last  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                bus.o_byte_valid = 1'b0;
                if (accept && !reject)
                    state_next = next_present(ST_IDLE, {bus.i_address_size, bus.i_operand_size,
                                                        seg_present_in,
                                                        bus.i_group_1_select != G1_NONE});
            end
            ST_G1, ST_SEG, ST_OPSZ, ST_ADSZ: begin
                case (state_reg)
                    ST_G1:   bus.o_byte = g1_byte;
                    ST_SEG:  bus.o_byte = seg_byte_reg;
                    ST_OPSZ: bus.o_byte = PREFIX_OPSZ;
                    default: bus.o_byte = PREFIX_ADSZ;
                endcase
                if (bus.i_byte_ready)
                    state_next = next_present(state_reg, {adsz_reg, opsz_reg, seg_present_reg,
                                                          g1_reg != G1_NONE});
            end
            ST_BODY: begin
                bus.o_byte      = body_flat[{index_reg, 3'b000} +: 8];
                bus.o_byte_last = body_last;
                if (bus.i_byte_ready) begin
                    if (body_last) begin
                        state_next = ST_IDLE;
                        index_next = 4'd0;
                    end else begin
                        index_next = index_reg + 4'd1;
                    end
                end
            end
            default: begin
                bus.o_byte_valid = 1'b0;
                state_next       = ST_IDLE;
                index_next       = 4'd0;
            end
        endcase
    end

    assign bus.o_ready        = (state_reg == ST_IDLE);
    assign bus.o_busy         = (state_reg != ST_IDLE);
    assign bus.o_length_error = length_error_reg;

endmodule

// File: tb/tb_encode_prefix.sv
// Directed self-checking bench for encode_prefix: prefix ordering, stalls, rejection, length limit, reset.
module tb_encode_prefix;
    import prefix_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    encode_prefix_if bus();

    encode_prefix dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] stim_body [15];
    logic [7:0] got_byte [$];
    logic       got_last [$];
    logic       log_valid [$];
    logic [7:0] log_byte [$];
    logic       log_err [$];
    int         cap_cycles;
    logic       cap_timeout;

    task automatic drive_req(input logic [1:0] g1, input logic se, input logic [2:0] si,
                             input logic op, input logic ad, input logic [3:0] len);
        bus.i_group_1_select         = group_1_t'(g1);
        bus.i_segment_override_en    = se;
        bus.i_segment_override_index = si;
        bus.i_operand_size           = op;
        bus.i_address_size           = ad;
        bus.i_body_length            = len;
        for (int i = 0; i < 15; i++) bus.i_body[i] = stim_body[i];
        bus.i_valid = 1'b1;
    endtask

    task automatic send(input logic [1:0] g1, input logic se, input logic [2:0] si,
                        input logic op, input logic ad, input logic [3:0] len);
        drive_req(g1, se, si, op, ad, len);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    // Drives i_byte_ready from rdy_pat (bit per cycle) and records the stream until n handshakes.
    task automatic capture(input int n, input logic [31:0] rdy_pat);
        got_byte.delete(); got_last.delete();
        log_valid.delete(); log_byte.delete(); log_err.delete();
        cap_cycles  = 0;
        cap_timeout = 1'b0;
        while (got_byte.size() < n) begin
            if (cap_cycles >= 64) begin
                cap_timeout = 1'b1;
                break;
            end
            bus.i_byte_ready = (cap_cycles < 32) ? rdy_pat[cap_cycles] : 1'b1;
            log_valid.push_back(bus.o_byte_valid);
            log_byte.push_back(bus.o_byte);
            log_err.push_back(bus.o_length_error);
            if (bus.o_byte_valid && bus.i_byte_ready) begin
                got_byte.push_back(bus.o_byte);
                got_last.push_back(bus.o_byte_last);
            end
            cap_cycles++;
            @(posedge clk); #1;
        end
        bus.i_byte_ready = 1'b1;
    endtask

    task automatic test_reset();
        bus.i_valid = 1'b0;
        bus.i_byte_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.o_ready); end
        checks++; if (bus.o_byte_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.o_byte_valid); end
        checks++; if (bus.o_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", bus.o_byte); end
        checks++; if (bus.o_byte_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", bus.o_byte_last); end
        checks++; if (bus.o_length_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.o_length_error); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset: released");
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [4];
        exp_b = '{8'hF3, 8'h3E, 8'h66, 8'hA5};
        stim_body[0] = 8'hA5;
        send(2'd3, 1'b1, 3'd3, 1'b1, 1'b0, 4'd1);
        capture(4, '1);
        checks++; if (cap_timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b expected 0", cap_timeout); end
        checks++; if (log_valid[0] !== 1'b1) begin errors++; $display("FAIL basic_first_latency: got %b expected 1", log_valid[0]); end
        checks++; if (cap_cycles !== 4) begin errors++; $display("FAIL basic_cycles: got %0d expected 4", cap_cycles); end
        for (int i = 0; i < 4; i++) begin
            if (i < got_byte.size()) begin
                checks++; if (got_byte[i] !== exp_b[i]) begin errors++; $display("FAIL basic_byte%0d: got %h expected %h", i, got_byte[i], exp_b[i]); end
                checks++; if (got_last[i] !== (i == 3)) begin errors++; $display("FAIL basic_last%0d: got %b expected %b", i, got_last[i], (i == 3)); end
            end
        end
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b expected 1", bus.o_ready); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", bus.o_busy); end
        $display("basic: F3 3E 66 A5 bytes=%0d cycles=%0d", got_byte.size(), cap_cycles);
    endtask

    task automatic test_stall();
        logic [7:0] exp_b [3];
        logic [7:0] exp_log [5];
        exp_b   = '{8'h0F, 8'hB6, 8'hC3};
        exp_log = '{8'h0F, 8'hB6, 8'hB6, 8'hB6, 8'hC3};
        stim_body[0] = 8'h0F; stim_body[1] = 8'hB6; stim_body[2] = 8'hC3;
        send(2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd3);
        capture(3, 32'b11001);
        checks++; if (cap_cycles !== 5) begin errors++; $display("FAIL stall_cycles: got %0d expected 5", cap_cycles); end
        checks++; if (got_byte.size() !== 3) begin errors++; $display("FAIL stall_count: got %0d expected 3", got_byte.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < log_byte.size()) begin
                checks++; if (log_byte[i] !== exp_log[i] || log_valid[i] !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: got %h/%b expected %h/1", i, log_byte[i], log_valid[i], exp_log[i]); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (i < got_byte.size()) begin
                checks++; if (got_byte[i] !== exp_b[i] || got_last[i] !== (i == 2)) begin errors++; $display("FAIL stall_byte%0d: got %h/%b expected %h/%b", i, got_byte[i], got_last[i], exp_b[i], (i == 2)); end
            end
        end
        $display("stall: 0F B6 C3 bytes=%0d cycles=%0d", got_byte.size(), cap_cycles);
    endtask

    task automatic test_seg_suppress();
        logic [7:0] exp_b [4];
        logic any_err;
        exp_b = '{8'hF0, 8'h67, 8'hFF, 8'h06};
        stim_body[0] = 8'hFF; stim_body[1] = 8'h06;
        send(2'd1, 1'b1, 3'd6, 1'b0, 1'b1, 4'd2);
        capture(4, '1);
        any_err = 1'b0;
        foreach (log_err[i]) any_err |= log_err[i];
        checks++; if (any_err !== 1'b0) begin errors++; $display("FAIL segsup_err: got %b expected 0", any_err); end
        checks++; if (cap_cycles !== 4) begin errors++; $display("FAIL segsup_cycles: got %0d expected 4", cap_cycles); end
        for (int i = 0; i < 4; i++) begin
            if (i < got_byte.size()) begin
                checks++; if (got_byte[i] !== exp_b[i] || got_last[i] !== (i == 3)) begin errors++; $display("FAIL segsup_byte%0d: got %h/%b expected %h/%b", i, got_byte[i], got_last[i], exp_b[i], (i == 3)); end
            end
        end
        $display("seg_suppress: F0 67 FF 06 bytes=%0d", got_byte.size());
    endtask

    task automatic test_reject();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) drive_req(2'd3, 1'b1, 3'd0, 1'b1, 1'b1, 4'd12);
            else        drive_req(2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
            @(posedge clk); #1;
            bus.i_valid = 1'b0;
            checks++; if (bus.o_length_error !== 1'b1) begin errors++; $display("FAIL reject%0d_pulse: got %b expected 1", k, bus.o_length_error); end
            checks++; if (bus.o_byte_valid !== 1'b0) begin errors++; $display("FAIL reject%0d_valid: got %b expected 0", k, bus.o_byte_valid); end
            checks++; if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL reject%0d_idle: got ready=%b busy=%b expected 1/0", k, bus.o_ready, bus.o_busy); end
            @(posedge clk); #1;
            checks++; if (bus.o_length_error !== 1'b0) begin errors++; $display("FAIL reject%0d_pulse_end: got %b expected 0", k, bus.o_length_error); end
            checks++; if (bus.o_byte_valid !== 1'b0) begin errors++; $display("FAIL reject%0d_valid2: got %b expected 0", k, bus.o_byte_valid); end
            $display("reject: case %0d length_error pulsed", k);
        end
    endtask

    task automatic test_boundary();
        logic [7:0] exp_b [15];
        exp_b[0] = 8'hF2; exp_b[1] = 8'h26; exp_b[2] = 8'h66; exp_b[3] = 8'h67;
        for (int i = 0; i < 11; i++) begin
            stim_body[i] = 8'h10 + 8'(i);
            exp_b[4+i]   = 8'h10 + 8'(i);
        end
        send(2'd2, 1'b1, 3'd0, 1'b1, 1'b1, 4'd11);
        capture(15, '1);
        checks++; if (got_byte.size() !== 15) begin errors++; $display("FAIL boundary_count: got %0d expected 15", got_byte.size()); end
        checks++; if (cap_cycles !== 15) begin errors++; $display("FAIL boundary_cycles: got %0d expected 15", cap_cycles); end
        checks++; if (log_err[0] !== 1'b0) begin errors++; $display("FAIL boundary_err: got %b expected 0", log_err[0]); end
        for (int i = 0; i < 15; i++) begin
            if (i < got_byte.size()) begin
                checks++; if (got_byte[i] !== exp_b[i] || got_last[i] !== (i == 14)) begin errors++; $display("FAIL boundary_byte%0d: got %h/%b expected %h/%b", i, got_byte[i], got_last[i], exp_b[i], (i == 14)); end
            end
        end
        $display("boundary: 15-byte instruction bytes=%0d", got_byte.size());
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_b [3];
        exp_b = '{8'hF2, 8'h65, 8'hC3};
        stim_body[0] = 8'h90; stim_body[1] = 8'h91; stim_body[2] = 8'h92; stim_body[3] = 8'h93;
        send(2'd1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd4);
        capture(2, '1);
        checks++; if (bus.o_byte_valid !== 1'b1 || bus.o_byte !== 8'h91) begin errors++; $display("FAIL midrst_pre: got %b/%h expected 1/91", bus.o_byte_valid, bus.o_byte); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_byte_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", bus.o_byte_valid); end
        checks++; if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: got ready=%b busy=%b expected 1/0", bus.o_ready, bus.o_busy); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.o_byte_valid !== 1'b0) begin errors++; $display("FAIL midrst_after: got %b expected 0", bus.o_byte_valid); end
        stim_body[0] = 8'hC3;
        send(2'd2, 1'b1, 3'd5, 1'b0, 1'b0, 4'd1);
        capture(3, '1);
        checks++; if (got_byte.size() !== 3) begin errors++; $display("FAIL midrst_next_count: got %0d expected 3", got_byte.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < got_byte.size()) begin
                checks++; if (got_byte[i] !== exp_b[i] || got_last[i] !== (i == 2)) begin errors++; $display("FAIL midrst_next%0d: got %h/%b expected %h/%b", i, got_byte[i], got_last[i], exp_b[i], (i == 2)); end
            end
        end
        $display("reset_mid: abandoned after 2 bytes, next bytes=%0d", got_byte.size());
    endtask

    task automatic test_back_to_back();
        stim_body[0] = 8'hAA;
        drive_req(2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd1);
        @(posedge clk); #1;
        // Second request presented while busy; it must wait and not disturb the first.
        stim_body[0] = 8'hBB;
        drive_req(2'd0, 1'b0, 3'd0, 1'b1, 1'b0, 4'd1);
        checks++; if (bus.o_byte_valid !== 1'b1 || bus.o_byte !== 8'hAA || bus.o_byte_last !== 1'b1) begin errors++; $display("FAIL b2b_first: got %b/%h/%b expected 1/aa/1", bus.o_byte_valid, bus.o_byte, bus.o_byte_last); end
        checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy: got %b expected 0", bus.o_ready); end
        @(posedge clk); #1;
        checks++; if (bus.o_ready !== 1'b1 || bus.o_byte_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got ready=%b valid=%b expected 1/0", bus.o_ready, bus.o_byte_valid); end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        capture(2, '1);
        checks++; if (got_byte.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", got_byte.size()); end
        if (got_byte.size() == 2) begin
            checks++; if (got_byte[0] !== 8'h66 || got_byte[1] !== 8'hBB || got_last[1] !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h %h/%b expected 66 bb/1", got_byte[0], got_byte[1], got_last[1]); end
        end
        $display("back_to_back: AA then 66 BB");
    endtask

    initial begin
        bus.i_valid                  = 1'b0;
        bus.i_group_1_select         = G1_NONE;
        bus.i_segment_override_en    = 1'b0;
        bus.i_segment_override_index = 3'd0;
        bus.i_operand_size           = 1'b0;
        bus.i_address_size           = 1'b0;
        bus.i_body_length            = 4'd0;
        bus.i_byte_ready             = 1'b1;
        for (int i = 0; i < 15; i++) begin
            stim_body[i]  = 8'h00;
            bus.i_body[i] = 8'h00;
        end
        test_reset();
        test_basic();
        test_stall();
        test_seg_suppress();
        test_reject();
        test_boundary();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
